// File: rtl/draw_arbiter.sv
// Three-way fixed-priority arbiter that hands the VGA adapter write port to one
// drawer at a time, with a no-plot watchdog and a per-grant pixel counter.
module draw_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [2:0]  req,
   input  logic [2:0]  done,
   input  logic [2:0]  plot_in,
   input  logic [23:0] x_in,
   input  logic [20:0] y_in,
   input  logic [8:0]  colour_in,
   output logic [2:0]  grant,
   output logic [7:0]  vga_x,
   output logic [6:0]  vga_y,
   output logic [2:0]  vga_colour,
   output logic        vga_plot,
   output logic        busy,
   output logic        timeout,
   output logic [14:0] pix_count,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT);
   localparam logic [14:0] PIX_MAX   = 15'h7FFF;

   state_t      state_q, state_d;
   logic [2:0]  grant_q, grant_d;
   logic [7:0]  vga_x_q, vga_x_d;
   logic [6:0]  vga_y_q, vga_y_d;
   logic [2:0]  vga_colour_q, vga_colour_d;
   logic        vga_plot_q, vga_plot_d;
   logic [7:0]  wd_q, wd_d;
   logic [14:0] pix_q, pix_d;

   logic [2:0]  pick;
   logic        g_req, g_done, g_plot;
   logic [7:0]  g_x;
   logic [6:0]  g_y;
   logic [2:0]  g_colour;
   logic        in_grant, g_end, wd_hit;

   // Lowest index wins: map, then link, then enemies.
   always_comb begin
      pick = 3'b000;
      if (req[0])      pick = 3'b001;
      else if (req[1]) pick = 3'b010;
      else if (req[2]) pick = 3'b100;
   end

   // Only the granted requester's strobes and fields are ever looked at.
   always_comb begin
      g_req    = req[0];
      g_done   = done[0];
      g_plot   = plot_in[0];
      g_x      = x_in[7:0];
      g_y      = y_in[6:0];
      g_colour = colour_in[2:0];
      if (grant_q[1]) begin
         g_req    = req[1];
         g_done   = done[1];
         g_plot   = plot_in[1];
         g_x      = x_in[15:8];
         g_y      = y_in[13:7];
         g_colour = colour_in[5:3];
      end else if (grant_q[2]) begin
         g_req    = req[2];
         g_done   = done[2];
         g_plot   = plot_in[2];
         g_x      = x_in[23:16];
         g_y      = y_in[20:14];
         g_colour = colour_in[8:6];
      end
   end

   assign in_grant = (state_q == S_GRANT);
   // A dropped request counts as done, and done beats the watchdog.
   assign g_end    = g_done | ~g_req;
   assign wd_hit   = in_grant && (wd_q == TIMEOUT_C);

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      vga_x_d      = vga_x_q;
      vga_y_d      = vga_y_q;
      vga_colour_d = vga_colour_q;
      vga_plot_d   = 1'b0;
      wd_d         = wd_q;
      pix_d        = pix_q;
      unique case (state_q)
         S_IDLE: begin
            if (|req) begin
               state_d = S_GRANT;
               grant_d = pick;
               wd_d    = 8'd0;
               pix_d   = 15'd0;
            end
         end
         S_GRANT: begin
            vga_x_d      = g_x;
            vga_y_d      = g_y;
            vga_colour_d = g_colour;
            vga_plot_d   = g_plot;
            if (g_plot) begin
               wd_d = 8'd0;
               if (pix_q != PIX_MAX) pix_d = pix_q + 15'd1;
            end else begin
               wd_d = wd_q + 8'd1;
            end
            if (g_end || wd_hit) begin
               state_d = S_RELEASE;
               grant_d = 3'b000;
            end
         end
         S_RELEASE: begin
            state_d = S_IDLE;
            grant_d = 3'b000;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = 3'b000;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         grant_q      <= 3'b000;
         vga_x_q      <= 8'd0;
         vga_y_q      <= 7'd0;
         vga_colour_q <= 3'd0;
         vga_plot_q   <= 1'b0;
         wd_q         <= 8'd0;
         pix_q        <= 15'd0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         vga_colour_q <= vga_colour_d;
         vga_plot_q   <= vga_plot_d;
         wd_q         <= wd_d;
         pix_q        <= pix_d;
      end
   end

   // vga_plot is a one-cycle valid for vga_x/vga_y/vga_colour; the adapter
   // has no ready, so every strobe is accepted on the cycle it is shown.
   assign grant      = grant_q;
   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;
   assign vga_plot   = vga_plot_q;
   assign busy       = (state_q != S_IDLE);
   assign timeout    = wd_hit & ~g_end;
   assign pix_count  = pix_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Randomised bench for draw_arbiter: grant sessions are modelled as whole
// transactions; a monitor pops expected pixels and grants as the DUT shows them.
module tb_draw_arbiter;

   logic        clock = 1'b0;
   logic        resetn;
   logic [2:0]  req, done, plot_in;
   logic [23:0] x_in;
   logic [20:0] y_in;
   logic [8:0]  colour_in;
   logic [2:0]  grant;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        vga_plot, busy, timeout;
   logic [14:0] pix_count;
   logic [1:0]  state_dbg;

   draw_arbiter #(.TIMEOUT(255)) dut (
      .clock(clock), .resetn(resetn), .req(req), .done(done), .plot_in(plot_in),
      .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .grant(grant),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
      .busy(busy), .timeout(timeout), .pix_count(pix_count), .state_dbg(state_dbg)
   );

   always #10 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   logic [17:0] exp_q[$];
   logic [2:0]  gnt_q[$];
   logic [2:0]  cur_gnt = 3'b000;
   logic [2:0]  prev_grant = 3'b000;
   logic        mon_en = 1'b0;
   int          model_pix = 0;
   int          exp_timeouts = 0;
   int          seen_timeouts = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > 32767) ? 32767 : v;
   endfunction

   function automatic int lowest(input logic [2:0] r);
      for (int k = 0; k < 3; k++) if (r[k]) return k;
      return 0;
   endfunction

   // Monitor: pixel stream, grant sequence and timeout pulses.
   always @(negedge clock) begin
      if (mon_en) begin
         if (vga_plot === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL pix_unexpected: got plot at x=%0d y=%0d c=%0d, required no plot",
                        vga_x, vga_y, vga_colour);
            end else begin
               check("pixel", {14'd0, vga_x, vga_y, vga_colour}, {14'd0, exp_q.pop_front()});
            end
         end
         if (timeout === 1'b1) seen_timeouts++;
         if (grant !== 3'b000 && prev_grant === 3'b000) begin
            if (gnt_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL grant_unexpected: got %0b, required none", grant);
            end else begin
               cur_gnt = gnt_q.pop_front();
               check("grant", {29'd0, grant}, {29'd0, cur_gnt});
            end
         end else if (grant !== 3'b000) begin
            check("grant_hold", {29'd0, grant}, {29'd0, cur_gnt});
         end
         prev_grant = grant;
      end
   end

   task automatic next_cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic rand_fields(output logic [23:0] xv, output logic [20:0] yv, output logic [8:0] cv);
      for (int k = 0; k < 3; k++) begin
         xv[8*k +: 8] = 8'($urandom_range(159, 0));
         yv[7*k +: 7] = 7'($urandom_range(119, 0));
         cv[3*k +: 3] = 3'($urandom);
      end
   endtask

   // One granted cycle; other requesters get random noise on every field.
   task automatic drive_grant_cycle(input int w, input logic plot_w, input logic done_w,
                                    input logic req_w, input logic directed);
      logic [23:0] xv;
      logic [20:0] yv;
      logic [8:0]  cv;
      logic [2:0]  pv, dv, rv;
      rand_fields(xv, yv, cv);
      pv = 3'($urandom);
      dv = 3'($urandom);
      rv = 3'($urandom);
      if (directed) begin
         xv[8*w +: 8] = 8'd42;
         yv[7*w +: 7] = 7'd17;
         cv[3*w +: 3] = 3'b101;
         if (w != 0) pv[0] = 1'b1;
      end
      pv[w] = plot_w;
      dv[w] = done_w;
      rv[w] = req_w;
      req = rv; done = dv; plot_in = pv;
      x_in = xv; y_in = yv; colour_in = cv;
      if (plot_w) begin
         exp_q.push_back({xv[8*w +: 8], yv[7*w +: 7], cv[3*w +: 3]});
         model_pix++;
      end
   endtask

   // Starts at the negedge of an idle cycle and ends at the negedge of the
   // idle cycle that follows the release. pol: 0 random, 1 always plot,
   // 2 never plot. mode: 0 done, 1 req drop, 2 watchdog, 3 done at watchdog.
   task automatic session(input logic [2:0] reqs, input int ncyc, input int pol,
                          input int mode, input logic [2:0] post_req, input logic directed);
      int   w;
      logic pw;
      #1;
      req = reqs; done = 3'b000; plot_in = 3'b000;
      w = lowest(reqs);
      gnt_q.push_back(3'(1 << w));
      model_pix = 0;
      for (int i = 0; i < ncyc; i++) begin
         next_cyc();
         pw = (pol == 1) ? 1'b1 : (pol == 2) ? 1'b0 : 1'($urandom_range(1, 0));
         drive_grant_cycle(w, pw, 1'b0, 1'b1, directed && (i == 0));
      end
      next_cyc();
      pw = (pol == 1) ? 1'b1 : (pol == 2) ? 1'b0 : 1'($urandom_range(1, 0));
      case (mode)
         0:       drive_grant_cycle(w, pw, 1'b1, 1'b1, 1'b0);
         1:       drive_grant_cycle(w, pw, 1'b0, 1'b0, 1'b0);
         2:       drive_grant_cycle(w, 1'b0, 1'b0, 1'b1, 1'b0);
         default: drive_grant_cycle(w, 1'b0, 1'b1, 1'b1, 1'b0);
      endcase
      if (mode == 2) exp_timeouts++;
      if (mode >= 2) begin
         @(negedge clock);
         check("timeout_pulse", {31'd0, timeout}, (mode == 2) ? 32'd1 : 32'd0);
         check("grant_at_watchdog", {29'd0, grant}, 32'(1 << w));
      end
      next_cyc();
      req = post_req; done = 3'b000; plot_in = 3'b000;
      @(negedge clock);
      check("release_grant", {29'd0, grant}, 32'd0);
      check("release_busy", {31'd0, busy}, 32'd1);
      check("release_timeout", {31'd0, timeout}, 32'd0);
      check("pix_count", {17'd0, pix_count}, 32'(sat(model_pix)));
      next_cyc();
      @(negedge clock);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("pix_count_hold", {17'd0, pix_count}, 32'(sat(model_pix)));
   endtask

   initial begin
      resetn = 1'b0;
      req = 3'b111; done = 3'b000; plot_in = 3'b111;
      x_in = 24'd0; y_in = 21'd0; colour_in = 9'h1FF;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_grant", {29'd0, grant}, 32'd0);
      check("rst_vga_x", {24'd0, vga_x}, 32'd0);
      check("rst_vga_y", {25'd0, vga_y}, 32'd0);
      check("rst_vga_colour", {29'd0, vga_colour}, 32'd0);
      check("rst_vga_plot", {31'd0, vga_plot}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_timeout", {31'd0, timeout}, 32'd0);
      check("rst_pix_count", {17'd0, pix_count}, 32'd0);
      check("rst_state", {30'd0, state_dbg}, 32'd0);
      next_cyc();
      resetn = 1'b1; req = 3'b000; plot_in = 3'b000;
      mon_en = 1'b1;
      @(negedge clock);

      session(3'b111, 5, 0, 0, 3'b110, 1'b0);
      session(3'b110, 6, 0, 0, 3'b010, 1'b1);
      session(3'b010, 4, 0, 1, 3'b100, 1'b0);
      session(3'b100, 8, 1, 0, 3'b000, 1'b0);
      repeat (25) begin
         session(3'($urandom_range(7, 1)), $urandom_range(40, 0), 0,
                 $urandom_range(1, 0), 3'($urandom), 1'b0);
      end
      session(3'b010, 255, 2, 2, 3'b000, 1'b0);
      session(3'b001, 255, 2, 3, 3'b000, 1'b0);
      session(3'b001, 19199, 1, 0, 3'b000, 1'b0);
      session(3'b001, 39999, 1, 0, 3'b000, 1'b0);

      // Reset in the middle of an enemy grant.
      #1;
      req = 3'b100; done = 3'b000; plot_in = 3'b000;
      gnt_q.push_back(3'b100);
      for (int i = 0; i < 4; i++) begin
         next_cyc();
         drive_grant_cycle(2, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      next_cyc();
      resetn = 1'b0; plot_in = 3'b000; done = 3'b000;
      @(negedge clock);
      next_cyc();
      @(negedge clock);
      check("midrst_grant", {29'd0, grant}, 32'd0);
      check("midrst_vga_plot", {31'd0, vga_plot}, 32'd0);
      check("midrst_pix_count", {17'd0, pix_count}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      next_cyc();
      resetn = 1'b1; req = 3'b000;
      @(negedge clock);
      session(3'b011, 3, 0, 0, 3'b000, 1'b0);

      repeat (3) @(negedge clock);
      check("pixels_left", 32'(exp_q.size()), 32'd0);
      check("grants_left", 32'(gnt_q.size()), 32'd0);
      check("timeout_count", 32'(seen_timeouts), 32'(exp_timeouts));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/draw_arbiter.md
DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning consecutive granted cycles without a plot before the grant is revoked; legal range 1-255.
REQ-002 clock  in  1  system clock (CLOCK_50); all logic on its rising edge.
REQ-003 resetn  in  1  one clock; reset is synchronous and active-low.
REQ-004 req  in  3  draw requests: [0]=map drawer, [1]=link drawer, [2]=enemy drawer.
REQ-005 done  in  3  per-requester last-pixel pulse, one cycle.
REQ-006 plot_in  in  3  per-requester pixel-valid strobe.
REQ-007 x_in  in  24  three 8-bit x coordinates, requester i at bits [8i+7:8i], range 0-159.
REQ-008 y_in  in  21  three 7-bit y coordinates, requester i at bits [7i+6:7i], range 0-119.
REQ-009 colour_in  in  9  three 3-bit colours, requester i at bits [3i+2:3i].
REQ-010 grant  out  3  one-hot grant, registered.
REQ-011 vga_x  out  8, vga_y  out  7, vga_colour  out  3, vga_plot  out  1: registered VGA adapter write port.
REQ-012 busy  out  1  high whenever the state is not S_IDLE.
REQ-013 timeout  out  1  one-cycle pulse on grant revocation by watchdog.
REQ-014 pix_count  out  15  pixels forwarded during the current or most recent grant.

Function
REQ-015 States SHALL be S_IDLE, S_GRANT and S_RELEASE; the state is held in a registered encoding.
REQ-016 S_IDLE: if any req bit is high, the block SHALL enter S_GRANT on the next edge with grant set to the lowest-index requesting bit (map > link > enemies); otherwise it stays in S_IDLE.
REQ-017 S_GRANT: grant SHALL remain constant; req changes from other requesters SHALL NOT preempt.
REQ-018 Datapath: on each S_GRANT cycle, vga_x/vga_y/vga_colour SHALL register the granted requester's fields, and vga_plot SHALL register plot_in[g]; latency is exactly 1 cycle.
REQ-019 plot_in, done and coordinate fields from non-granted requesters SHALL be ignored.
REQ-020 Outside S_GRANT, vga_plot SHALL be 0 on the following cycle; vga_x/vga_y/vga_colour hold their last values.
REQ-021 done[g] high in S_GRANT SHALL move the state to S_RELEASE; a plot_in[g] in that same cycle SHALL still be forwarded.
REQ-022 req[g] low in S_GRANT without done[g] SHALL be treated as done, moving the state to S_RELEASE.
REQ-023 S_RELEASE SHALL last exactly one cycle with grant=0, then return to S_IDLE; minimum gap between consecutive grants is 2 cycles.
REQ-024 Watchdog: an 8-bit counter SHALL clear on entry to S_GRANT and on every forwarded plot, and increment on each other S_GRANT cycle.
REQ-025 When the watchdog counter reaches TIMEOUT, the block SHALL pulse timeout for one cycle and enter S_RELEASE.
REQ-026 If done[g] and the timeout condition occur in the same cycle, done SHALL win and timeout SHALL stay 0.
REQ-027 pix_count SHALL clear on entry to S_GRANT and increment by 1 per forwarded plot.
REQ-028 pix_count SHALL saturate at 32767, hold after release, and not wrap.
REQ-029 A requester still requesting after its release SHALL be re-granted through S_IDLE under normal priority.

Reset
REQ-030 While resetn is 0 at a rising edge: state=S_IDLE, and grant, vga_x, vga_y, vga_colour, vga_plot, busy, timeout, pix_count and the watchdog counter SHALL all be 0.
REQ-031 resetn low mid-grant SHALL drop grant and vga_plot on that edge, with no S_RELEASE cycle.
REQ-032 Arbitration SHALL resume from S_IDLE on the first edge with resetn high.

Verification
REQ-033 req=3'b111 from S_IDLE -> grant=3'b001 next cycle; after map done -> S_RELEASE, then grant=3'b010.
REQ-034 Link granted, plot_in[1]=1 with x=42, y=17, colour=3'b101 -> next cycle vga_plot=1, vga_x=42, vga_y=17, vga_colour=5; plot_in[0]=1 concurrently has no effect.
REQ-035 Grant held with no plots, TIMEOUT=255 -> timeout=1 for one cycle at the 255th idle count, grant=0 the cycle after.
REQ-036 Map plots 19200 pixels then done -> pix_count=19200 and held; a 40000-plot run -> pix_count=32767.
REQ-037 done[2] and plot_in[2] in the same cycle -> final pixel forwarded, S_RELEASE, busy drops two cycles later.
REQ-038 resetn=0 during an enemy grant -> grant=0, vga_plot=0, pix_count=0 on the next edge.
